// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the EX-stage stall sequencer.
// Holds the mult/div sequencing state encoding and the hard-wired zero register index.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID cannot be covered by forwarding. Register 0 never hazards.
module ex_load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_usesRt,
  input  logic       ex_memRead,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  // Destination match against Rs always, against Rt only when ID reads it
  always_comb begin
    hazard = id_valid & ex_memRead & (ex_rt != REG_ZERO) &
             ((ex_rt == id_rs) | (id_usesRt & (ex_rt == id_rt)));
  end

endmodule

// File: rtl/ex_stall_sequencer.sv
// EX-stage stall/bubble controller: one-cycle load-use stalls and multi-cycle
// mult/div holds. Outputs are combinational decodes of state and inputs.
// Optional feature macro STALL_PERF_EN adds saturating 32-bit counters
// perf_luStall and perf_mduStall (and ports of the same names).
module ex_stall_sequencer
  import mips_pipe_pkg::*;
#(
  parameter int MDU_LATENCY = 32,  // EX cycles per mult/div including issue, 2..63
  parameter int CNT_W       = 6    // 2**CNT_W must exceed MDU_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_usesRt,
  input  logic        ex_memRead,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mduReq,
  input  logic        ex_abort,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexWrite,
  output logic        idexBubble,
  output logic        exmemBubble,
  output logic        mdu_start,
  output logic        mdu_done,
  output logic        busy
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_luStall,
  output logic [31:0] perf_mduStall
`endif
);

  // BUSY lasts MDU_LATENCY-1 cycles: counter runs from LATENCY-2 down to 0
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 2);

  mdu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             hazard;
  logic             issue;
  logic             holding;

  ex_load_use_detect u_detect (
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_usesRt  (id_usesRt),
    .ex_memRead (ex_memRead),
    .ex_rt      (ex_rt),
    .hazard     (hazard)
  );

  // Issue is a fresh mult/div seen while idle; in DONE the request is the same
  // instruction leaving EX, so it is not re-issued.
  assign issue   = (state == IDLE) & ex_mduReq;
  assign holding = issue | (state == BUSY);

  // Output decode: MDU hold wins over load-use, which only stalls when not holding
  always_comb begin
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    idexWrite   = 1'b1;
    idexBubble  = 1'b0;
    exmemBubble = 1'b0;
    mdu_start   = issue;
    mdu_done    = (state == DONE);
    busy        = (state != IDLE);
    if (holding) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      idexWrite   = 1'b0;
      exmemBubble = 1'b1;
    end else if (hazard) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end
  end

  // Next-state and counter: abort during issue or BUSY drops straight to IDLE
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (ex_mduReq && !ex_abort) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end else begin
          cnt_next = '0;
        end
      end
      BUSY: begin
        if (ex_abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

`ifdef STALL_PERF_EN
  logic lu_stall;
  assign lu_stall = hazard & ~holding;

  // Saturating stall-cycle counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_luStall  <= '0;
      perf_mduStall <= '0;
    end else begin
      if (lu_stall && (perf_luStall != 32'hFFFF_FFFF))
        perf_luStall <= perf_luStall + 32'd1;
      if (holding && (perf_mduStall != 32'hFFFF_FFFF))
        perf_mduStall <= perf_mduStall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_stall_sequencer.sv
// Self-checking bench for ex_stall_sequencer (MDU_LATENCY=4).
// Output vector order: {pcWrite,ifidWrite,idexWrite,idexBubble,exmemBubble,mdu_start,mdu_done,busy}.
module tb_ex_stall_sequencer;

  localparam int L = 4;

  localparam logic [7:0] V_RUN   = 8'hE0; // all writes on, no bubbles
  localparam logic [7:0] V_LU    = 8'h30; // load-use stall: idexWrite=1, idexBubble=1
  localparam logic [7:0] V_ISSUE = 8'h0C; // issue cycle: holds, exmemBubble, mdu_start
  localparam logic [7:0] V_BUSY  = 8'h09; // BUSY: holds, exmemBubble, busy
  localparam logic [7:0] V_DONE  = 8'hE3; // DONE: released, mdu_done, busy
  localparam logic [7:0] V_DONEH = 8'h33; // DONE with load-use stall

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_usesRt = 1'b0, ex_memRead = 1'b0, ex_mduReq = 1'b0, ex_abort = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic pcWrite, ifidWrite, idexWrite, idexBubble, exmemBubble, mdu_start, mdu_done, busy;
`ifdef STALL_PERF_EN
  logic [31:0] perf_luStall, perf_mduStall;
`endif

  logic [7:0] obs;
  assign obs = {pcWrite, ifidWrite, idexWrite, idexBubble, exmemBubble, mdu_start, mdu_done, busy};

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  int exp_lu = 0;
  int exp_mdu = 0;

  always #5 clk = ~clk;

  ex_stall_sequencer #(.MDU_LATENCY(L), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt), .ex_mduReq(ex_mduReq), .ex_abort(ex_abort),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
    .idexBubble(idexBubble), .exmemBubble(exmemBubble),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .busy(busy)
`ifdef STALL_PERF_EN
    , .perf_luStall(perf_luStall), .perf_mduStall(perf_mduStall)
`endif
  );

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] ert,
                       input logic mreq, input logic ab);
    id_valid = v; id_rs = rs; id_rt = rt; id_usesRt = urt;
    ex_memRead = mr; ex_rt = ert; ex_mduReq = mreq; ex_abort = ab;
  endtask

  // Queue an expected per-cycle vector and track expected stall-cycle counts
  function automatic void push_exp(input logic [7:0] v);
    sb.push_back(v);
    if (v == V_LU || v == V_DONEH) exp_lu++;
    if (v == V_ISSUE || v == V_BUSY) exp_mdu++;
  endfunction

  task automatic test_reset();
    logic [7:0] e;
    #3 rst = 1'b0;
    #1;
    sb.push_back(V_RUN);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_async obs=%h exp=%h", obs, e); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back(V_RUN);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_held obs=%h exp=%h", obs, e); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    logic [7:0] e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin drive(1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0); push_exp(V_LU);  end // lw $5 / use $5 in Rs
        1: begin drive(1, 5'd5, 5'd0, 0, 0, 5'd9, 0, 0); push_exp(V_RUN); end // load moved on
        2: begin drive(1, 5'd1, 5'd7, 1, 1, 5'd7, 0, 0); push_exp(V_LU);  end // Rt hazard
        3: begin drive(1, 5'd1, 5'd7, 0, 1, 5'd7, 0, 0); push_exp(V_RUN); end // Rt not read
        4: begin drive(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0); push_exp(V_RUN); end // $0 never hazards
        default: begin drive(0, 5'd5, 5'd5, 1, 1, 5'd5, 0, 0); push_exp(V_RUN); end // ID empty
      endcase
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL load_use case%0d obs=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random_idle();
    logic [7:0] e;
    logic v, urt, mr, hz;
    logic [4:0] rs, rt, ert;
    for (int i = 0; i < 24; i++) begin
      v = 1'($urandom_range(0, 1)); urt = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1));
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); ert = 5'($urandom_range(0, 3));
      drive(v, rs, rt, urt, mr, ert, 0, 0);
      hz = v && mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
      push_exp(hz ? V_LU : V_RUN);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL random_idle it%0d obs=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  // Issue, L-1 BUSY cycles, DONE at T+L, IDLE at T+L+1
  task automatic test_mdu();
    logic [7:0] e;
    for (int i = 0; i <= L + 1; i++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, (i <= L), 0);
      push_exp(i == 0 ? V_ISSUE : (i < L ? V_BUSY : (i == L ? V_DONE : V_RUN)));
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mdu cyc%0d obs=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  // Load-use present throughout the hold: no idexBubble until released
  task automatic test_hazard_during_busy();
    logic [7:0] e;
    for (int i = 0; i <= L + 2; i++) begin
      drive(1, 5'd5, 5'd0, 0, (i <= L + 1), 5'd5, (i <= L), 0);
      push_exp(i == 0 ? V_ISSUE : (i < L ? V_BUSY : (i == L ? V_DONEH : (i == L + 1 ? V_LU : V_RUN))));
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL hz_busy cyc%0d obs=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    for (int i = 0; i < 2 * (L + 1) + 1; i++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, (i < 2 * (L + 1)), 0);
      push_exp(i == 2 * (L + 1) ? V_RUN :
               ((i % (L + 1)) == 0 ? V_ISSUE : ((i % (L + 1)) < L ? V_BUSY : V_DONE)));
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b cyc%0d obs=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  // Abort at the 2nd BUSY cycle, then abort in the issue cycle
  task automatic test_abort();
    logic [7:0] e;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin drive(0, 0, 0, 0, 0, 0, 1, 0); push_exp(V_ISSUE); end
        1: begin drive(0, 0, 0, 0, 0, 0, 1, 0); push_exp(V_BUSY);  end
        2: begin drive(0, 0, 0, 0, 0, 0, 1, 1); push_exp(V_BUSY);  end
        3, 4, 5: begin drive(0, 0, 0, 0, 0, 0, 0, 0); push_exp(V_RUN); end
        6: begin drive(0, 0, 0, 0, 0, 0, 1, 1); push_exp(V_ISSUE); end
        default: begin drive(0, 0, 0, 0, 0, 0, 0, i == 7); push_exp(V_RUN); end
      endcase
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL abort cyc%0d obs=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

`ifdef STALL_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    checks++;
    if (perf_luStall !== 32'(exp_lu)) begin
      errors++; $display("FAIL perf_lu obs=%0d exp=%0d", perf_luStall, exp_lu);
    end
    checks++;
    if (perf_mduStall !== 32'(exp_mdu)) begin
      errors++; $display("FAIL perf_mdu obs=%0d exp=%0d", perf_mduStall, exp_mdu);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_mid_busy();
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      push_exp(i == 0 ? V_ISSUE : V_BUSY);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_busy cyc%0d obs=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    exp_lu = 0; exp_mdu = 0;
    sb.push_back(V_RUN);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_busy_async obs=%h exp=%h", obs, e); end
`ifdef STALL_PERF_EN
    checks++;
    if ((perf_luStall !== 32'd0) || (perf_mduStall !== 32'd0)) begin
      errors++; $display("FAIL perf_after_rst obs=%0d/%0d exp=0/0", perf_luStall, perf_mduStall);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    push_exp(V_RUN);
    @(negedge clk);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_busy_after obs=%h exp=%h", obs, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_random_idle();
    test_mdu();
    test_hazard_during_busy();
    test_back_to_back();
    test_abort();
`ifdef STALL_PERF_EN
    test_perf();
`endif
    test_reset_mid_busy();
`ifdef STALL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
